// File: rtl/seq_clk_pkg.sv
// Shared types and widths for the sequence clock aligner.
package seq_clk_pkg;

    localparam int unsigned REF_PERIOD_NS_DEF = 25000;
    localparam int unsigned TIME_W            = 64;
    localparam int unsigned DIV_W             = 64;
    localparam int unsigned DVSR_W            = 17;
    localparam int unsigned IDX_W             = 16;
    localparam int unsigned CNT_W             = 7;
    localparam int unsigned MISS_W            = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_D_TICK = 3'd1,
        ST_D_PT   = 3'd2,
        ST_D_MOD  = 3'd3,
        ST_ARMED  = 3'd4,
        ST_RUN    = 3'd5
    } seq_align_state_t;

endpackage

// File: rtl/seq_clk_aligner_if.sv
// Config/sync inputs and sequence-index outputs of the aligner.
// SEQ_SYNC_MISS_CNT_EN adds the sync_miss_cnt signal.
interface seq_clk_aligner_if;
    import seq_clk_pkg::*;

    logic                seq_clk_init;
    logic [TIME_W-1:0]   seq_clk_sync_time_ns;
    logic [IDX_W-1:0]    seq_clk_div;
    logic [IDX_W-1:0]    seq_clk_cycle;
    logic                op_mode;
    logic                ref_clk_tick;
    logic                sync;
    logic [IDX_W-1:0]    seq_idx;
    logic                seq_tick;
    logic                seq_idx_valid;
    logic                busy;
`ifdef SEQ_SYNC_MISS_CNT_EN
    logic [MISS_W-1:0]   sync_miss_cnt;

    modport master (
        output seq_clk_init, seq_clk_sync_time_ns, seq_clk_div, seq_clk_cycle,
               op_mode, ref_clk_tick, sync,
        input  seq_idx, seq_tick, seq_idx_valid, busy, sync_miss_cnt
    );
    modport slave (
        input  seq_clk_init, seq_clk_sync_time_ns, seq_clk_div, seq_clk_cycle,
               op_mode, ref_clk_tick, sync,
        output seq_idx, seq_tick, seq_idx_valid, busy, sync_miss_cnt
    );
`else
    modport master (
        output seq_clk_init, seq_clk_sync_time_ns, seq_clk_div, seq_clk_cycle,
               op_mode, ref_clk_tick, sync,
        input  seq_idx, seq_tick, seq_idx_valid, busy
    );
    modport slave (
        input  seq_clk_init, seq_clk_sync_time_ns, seq_clk_div, seq_clk_cycle,
               op_mode, ref_clk_tick, sync,
        output seq_idx, seq_tick, seq_idx_valid, busy
    );
`endif

endinterface

// File: rtl/seq_iter_div.sv
// Unsigned restoring divider, one quotient bit per cycle; start reloads at any time.
module seq_iter_div
    import seq_clk_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIV_W-1:0]  dividend,
    input  logic [DVSR_W-1:0] divisor,
    output logic              done,
    output logic [DIV_W-1:0]  quot,
    output logic [DVSR_W-1:0] rem
);

    logic [DVSR_W-1:0] dvsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              run_q;
    logic [DVSR_W:0]   trial;
    logic              ge;

    // Partial remainder with the next dividend bit shifted in, and its compare.
    always_comb begin
        trial = {rem, quot[DIV_W-1]};
        ge    = (trial >= {1'b0, dvsr_q});
    end

    // quot doubles as the dividend shift register; rem is the running remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot   <= '0;
            rem    <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quot   <= dividend;
                rem    <= '0;
                dvsr_q <= divisor;
                cnt_q  <= CNT_W'(DIV_W);
                run_q  <= 1'b1;
            end else if (run_q) begin
                quot  <= {quot[DIV_W-2:0], ge};
                rem   <= ge ? DVSR_W'(trial - {1'b0, dvsr_q}) : DVSR_W'(trial);
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    run_q <= 1'b0;
                    done  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_clk_aligner.sv
// Sequence point index generator, phase-aligned at the global SYNC edge.
// Optional macro SEQ_SYNC_MISS_CNT_EN: count of SYNC pulses seen while busy.
module seq_clk_aligner
    import seq_clk_pkg::*;
#(
    parameter int unsigned REF_PERIOD_NS = REF_PERIOD_NS_DEF
) (
    input logic              clk,
    input logic              rst_n,
    seq_clk_aligner_if.slave bus
);

    seq_align_state_t  state_q;
    logic              init_q;
    logic              init_rise;
    logic [IDX_W-1:0]  div_q;
    logic [IDX_W-1:0]  cyc_q;
    logic [IDX_W-1:0]  phase_q;
    logic [IDX_W-1:0]  idx0_q;
    logic [IDX_W-1:0]  cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              tick_q;
    logic              busy_q;

    logic              div_start;
    logic [DIV_W-1:0]  div_dividend;
    logic [DVSR_W-1:0] div_divisor;
    logic              div_done;
    logic [DIV_W-1:0]  div_quot;
    logic [DVSR_W-1:0] div_rem;

    // Launch the next division stage; each stage feeds on the previous quotient.
    always_comb begin
        init_rise    = bus.seq_clk_init & ~init_q;
        div_start    = 1'b0;
        div_dividend = div_quot;
        div_divisor  = DVSR_W'(div_q) + DVSR_W'(1);
        if (init_rise) begin
            div_start    = 1'b1;
            div_dividend = bus.seq_clk_sync_time_ns;
            div_divisor  = DVSR_W'(REF_PERIOD_NS);
        end else if (div_done && (state_q == ST_D_TICK)) begin
            div_start    = 1'b1;
            div_divisor  = DVSR_W'(div_q) + DVSR_W'(1);
        end else if (div_done && (state_q == ST_D_PT)) begin
            div_start    = 1'b1;
            div_divisor  = DVSR_W'(cyc_q) + DVSR_W'(1);
        end
    end

    seq_iter_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    // Alignment FSM and free-running point counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b0;
            div_q   <= '0;
            cyc_q   <= '0;
            phase_q <= '0;
            idx0_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            init_q <= bus.seq_clk_init;
            tick_q <= 1'b0;
            if (init_rise) begin
                div_q   <= bus.seq_clk_div;
                cyc_q   <= bus.seq_clk_cycle;
                busy_q  <= 1'b1;
                state_q <= ST_D_TICK;
            end else begin
                case (state_q)
                    ST_IDLE: ;
                    ST_D_TICK: begin
                        if (div_done) state_q <= ST_D_PT;
                    end
                    ST_D_PT: begin
                        if (div_done) begin
                            phase_q <= IDX_W'(div_rem);
                            state_q <= ST_D_MOD;
                        end
                    end
                    ST_D_MOD: begin
                        if (div_done) begin
                            idx0_q  <= IDX_W'(div_rem);
                            busy_q  <= 1'b0;
                            state_q <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        // A tick coinciding with SYNC is swallowed by the load.
                        if (bus.sync) begin
                            idx_q   <= idx0_q;
                            cnt_q   <= phase_q;
                            state_q <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (bus.ref_clk_tick) begin
                            if (cnt_q == div_q) begin
                                cnt_q  <= '0;
                                idx_q  <= (idx_q == cyc_q) ? '0 : idx_q + IDX_W'(1);
                                tick_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + IDX_W'(1);
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.seq_idx       = idx_q;
    assign bus.seq_tick      = tick_q;
    assign bus.busy          = busy_q;
    assign bus.seq_idx_valid = (state_q == ST_RUN) && bus.op_mode;

`ifdef SEQ_SYNC_MISS_CNT_EN
    logic [MISS_W-1:0] miss_q;

    // Saturating count of SYNC pulses that arrive while alignment is still computing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_q <= '0;
        end else if (init_rise) begin
            miss_q <= '0;
        end else if (bus.sync && (miss_q != '1) &&
                     ((state_q == ST_D_TICK) || (state_q == ST_D_PT) || (state_q == ST_D_MOD))) begin
            miss_q <= miss_q + MISS_W'(1);
        end
    end

    assign bus.sync_miss_cnt = miss_q;
`endif

endmodule

// File: tb/tb_seq_clk_aligner.sv
// Randomized self-checking bench for seq_clk_aligner against an arithmetic model.
module tb_seq_clk_aligner;
    import seq_clk_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    // Model: reference ticks since epoch, points-per-sequence and ticks-per-point.
    logic [63:0] m_t   = 64'd0;
    logic [63:0] m_dp1 = 64'd1;
    logic [63:0] m_cp1 = 64'd1;
    logic        m_op  = 1'b1;

    seq_clk_aligner_if bus();

    seq_clk_aligner #(.REF_PERIOD_NS(25000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_idx();
        return 16'((m_t / m_dp1) % m_cp1);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Re-arm with new settings, wait for the arithmetic to finish, then scramble the inputs.
    task automatic arm(input logic [63:0] t, input logic [15:0] d, input logic [15:0] c, input string name);
        int n;
        bus.seq_clk_sync_time_ns = t;
        bus.seq_clk_div          = d;
        bus.seq_clk_cycle        = c;
        bus.seq_clk_init         = 1'b1;
        cyc();
        bus.seq_clk_init = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL %s busy_after_init got %b expected 1", name, bus.busy);
        end
        checks++;
        if (bus.seq_idx_valid !== 1'b0) begin
            errors++; $display("FAIL %s valid_after_init got %b expected 0", name, bus.seq_idx_valid);
        end
        checks++;
        if (bus.seq_idx !== exp_idx()) begin
            errors++; $display("FAIL %s idx_hold_on_init got %0d expected %0d", name, bus.seq_idx, exp_idx());
        end
        n = 1;
        while (bus.busy === 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        checks++;
        if (n > 199) begin
            errors++; $display("FAIL %s busy_cycles got %0d expected <=199", name, n);
        end
        m_t   = t / 64'd25000;
        m_dp1 = 64'(d) + 64'd1;
        m_cp1 = 64'(c) + 64'd1;
        bus.seq_clk_sync_time_ns = {$urandom, $urandom};
        bus.seq_clk_div          = 16'($urandom);
        bus.seq_clk_cycle        = 16'($urandom);
    endtask

    task automatic do_sync(input string name);
        bus.sync = 1'b1;
        cyc();
        bus.sync = 1'b0;
        checks++;
        if (bus.seq_idx !== exp_idx()) begin
            errors++; $display("FAIL %s idx_at_sync got %0d expected %0d", name, bus.seq_idx, exp_idx());
        end
        checks++;
        if (bus.seq_idx_valid !== m_op) begin
            errors++; $display("FAIL %s valid_at_sync got %b expected %b", name, bus.seq_idx_valid, m_op);
        end
    endtask

    task automatic do_tick(input string name, input int gap);
        logic exp_tick;
        bus.ref_clk_tick = 1'b1;
        cyc();
        bus.ref_clk_tick = 1'b0;
        m_t++;
        exp_tick = ((m_t % m_dp1) == 64'd0);
        checks++;
        if (bus.seq_idx !== exp_idx()) begin
            errors++; $display("FAIL %s idx_after_tick got %0d expected %0d", name, bus.seq_idx, exp_idx());
        end
        checks++;
        if (bus.seq_tick !== exp_tick) begin
            errors++; $display("FAIL %s seq_tick got %b expected %b", name, bus.seq_tick, exp_tick);
        end
        for (int g = 0; g < gap; g++) begin
            cyc();
            checks++;
            if (bus.seq_tick !== 1'b0) begin
                errors++; $display("FAIL %s seq_tick_idle got %b expected 0", name, bus.seq_tick);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) cyc();
        checks++;
        if (bus.seq_idx !== 16'd0 || bus.seq_tick !== 1'b0 || bus.seq_idx_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL reset idx/tick/valid/busy got %0d/%b/%b/%b expected 0/0/0/0",
                               bus.seq_idx, bus.seq_tick, bus.seq_idx_valid, bus.busy);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_basic_wrap();
        arm(64'd0, 16'd0, 16'd3, "t1");
        do_sync("t1");
        for (int i = 0; i < 4; i++) do_tick("t1", 0);
    endtask

    task automatic test_phase();
        arm(64'd250000, 16'd1, 16'd3, "t2");
        do_sync("t2");
        for (int i = 0; i < 3; i++) do_tick("t2", 1);
        arm(64'd262499, 16'd1, 16'd3, "t3a");
        do_sync("t3a");
        for (int i = 0; i < 2; i++) do_tick("t3a", 0);
        arm(64'd275000, 16'd1, 16'd3, "t3b");
        do_sync("t3b");
        for (int i = 0; i < 3; i++) do_tick("t3b", 0);
    endtask

    task automatic test_large_time();
        arm(64'd1 << 40, 16'd9, 16'd999, "t4");
        do_sync("t4");
        for (int i = 0; i < 12; i++) do_tick("t4", int'($urandom_range(0, 2)));
    endtask

    task automatic test_init_restart();
        int n;
        logic [63:0] tb;
        bus.seq_clk_sync_time_ns = 64'd1 << 30;
        bus.seq_clk_div          = 16'd3;
        bus.seq_clk_cycle        = 16'd7;
        bus.seq_clk_init         = 1'b1;
        cyc();
        bus.seq_clk_init = 1'b0;
        checks++;
        if (bus.seq_idx !== exp_idx() || bus.seq_idx_valid !== 1'b0) begin
            errors++; $display("FAIL t5 hold_on_init idx/valid got %0d/%b expected %0d/0",
                               bus.seq_idx, bus.seq_idx_valid, exp_idx());
        end
        bus.sync = 1'b1;
        cyc();
        bus.sync = 1'b0;
        repeat (78) cyc();
        tb = {24'd0, 8'($urandom), $urandom};
        bus.seq_clk_sync_time_ns = tb;
        bus.seq_clk_div          = 16'd2;
        bus.seq_clk_cycle        = 16'd4;
        bus.seq_clk_init         = 1'b1;
        cyc();
        bus.seq_clk_init = 1'b0;
        bus.sync = 1'b1;
        cyc();
        bus.sync = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL t5 busy_after_sync got %b expected 1", bus.busy);
        end
        n = 0;
        while (bus.busy === 1'b1 && n < 400) begin
            cyc();
            n++;
        end
        checks++;
        if (n >= 400 || bus.seq_idx_valid !== 1'b0) begin
            errors++; $display("FAIL t5 armed_after_busy wait/valid got %0d/%b expected <400/0", n, bus.seq_idx_valid);
        end
`ifdef SEQ_SYNC_MISS_CNT_EN
        checks++;
        if (bus.sync_miss_cnt !== 8'd1) begin
            errors++; $display("FAIL t5 sync_miss_cnt got %0d expected 1", bus.sync_miss_cnt);
        end
`endif
        m_t   = tb / 64'd25000;
        m_dp1 = 64'd3;
        m_cp1 = 64'd5;
        do_sync("t5");
        for (int i = 0; i < 8; i++) do_tick("t5", 0);
    endtask

    task automatic test_sync_tick_opmode();
        arm({32'd0, $urandom}, 16'd4, 16'd5, "t6");
        bus.sync = 1'b1;
        bus.ref_clk_tick = 1'b1;
        cyc();
        bus.sync = 1'b0;
        bus.ref_clk_tick = 1'b0;
        checks++;
        if (bus.seq_idx !== exp_idx() || bus.seq_tick !== 1'b0) begin
            errors++; $display("FAIL t6 sync_tick_load idx/tick got %0d/%b expected %0d/0",
                               bus.seq_idx, bus.seq_tick, exp_idx());
        end
        for (int i = 0; i < 6; i++) do_tick("t6", 0);
        bus.op_mode = 1'b0;
        m_op = 1'b0;
        #1;
        checks++;
        if (bus.seq_idx_valid !== 1'b0) begin
            errors++; $display("FAIL t6 valid_opmode0 got %b expected 0", bus.seq_idx_valid);
        end
        for (int i = 0; i < 6; i++) do_tick("t6_op0", 1);
        bus.op_mode = 1'b1;
        m_op = 1'b1;
        #1;
        checks++;
        if (bus.seq_idx_valid !== 1'b1) begin
            errors++; $display("FAIL t6 valid_opmode1 got %b expected 1", bus.seq_idx_valid);
        end
    endtask

    task automatic test_cycle_zero();
        arm(64'd175000, 16'd2, 16'd0, "cyc0");
        do_sync("cyc0");
        for (int i = 0; i < 7; i++) do_tick("cyc0", 0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 5; k++) begin
            arm({24'd0, 8'($urandom), $urandom}, 16'($urandom_range(0, 5)), 16'($urandom_range(0, 6)), "rand");
            do_sync("rand");
            for (int i = 0; i < 20; i++) do_tick("rand", int'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_div();
        bus.seq_clk_sync_time_ns = 64'd123456789;
        bus.seq_clk_init = 1'b1;
        cyc();
        bus.seq_clk_init = 1'b0;
        repeat (40) cyc();
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.seq_idx !== 16'd0 || bus.seq_idx_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_div busy/idx/valid got %b/%0d/%b expected 0/0/0",
                               bus.busy, bus.seq_idx, bus.seq_idx_valid);
        end
        cyc();
        rst_n = 1'b1;
        repeat (2) cyc();
        checks++;
        if (bus.busy !== 1'b0 || bus.seq_tick !== 1'b0) begin
            errors++; $display("FAIL reset_release busy/tick got %b/%b expected 0/0", bus.busy, bus.seq_tick);
        end
    endtask

    initial begin
        bus.seq_clk_init         = 1'b0;
        bus.seq_clk_sync_time_ns = 64'd0;
        bus.seq_clk_div          = 16'd0;
        bus.seq_clk_cycle        = 16'd0;
        bus.op_mode              = 1'b1;
        bus.ref_clk_tick         = 1'b0;
        bus.sync                 = 1'b0;
        test_reset();
        test_basic_wrap();
        test_phase();
        test_large_time();
        test_init_restart();
        test_sync_tick_opmode();
        test_cycle_zero();
        test_random();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
